// File: rtl/framebuffer_port_arbiter.sv
// Arbiter between the panel scan reader and host pixel writer in front of one
// single-port synchronous-read frame-buffer RAM; reads win unless a held write starves.
module framebuffer_port_arbiter #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wr_pending,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                  en_q;
  logic                  hold_full;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [SW-1:0]         starve_cnt;
  logic [1:0]            vld_pipe;
  logic                  haz, wr_grant, rd_grant, wr_acc;

  always_comb begin
    haz      = rd_valid && hold_full && (rd_addr == hold_addr);
    // A read hitting the held address must wait for the drain, so it forces the write.
    wr_grant = en_q && hold_full &&
               (!rd_valid || haz || (starve_cnt == SW'(STARVE_LIMIT)));
    rd_grant = en_q && rd_valid && !wr_grant;
    wr_acc   = wr_valid && wr_ready;
  end

  assign vld_pipe[0]   = rd_grant;
  assign rd_ready      = rd_grant;
  assign rd_data_valid = vld_pipe[1];
  assign rd_data       = ram_dout;
  assign wr_ready      = en_q && (!hold_full || wr_grant);
  assign wr_pending    = hold_full;
  assign ram_we        = wr_grant;
  assign ram_addr      = wr_grant ? hold_addr : rd_addr;
  assign ram_din       = hold_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      hold_full   <= 1'b0;
      hold_addr   <= '0;
      hold_data   <= '0;
      starve_cnt  <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      en_q        <= 1'b1;
      vld_pipe[1] <= vld_pipe[0];
      // Accept takes precedence so a drain and refill in one cycle keeps the slot full.
      if (wr_acc) begin
        hold_full <= 1'b1;
        hold_addr <= wr_addr;
        hold_data <= wr_data;
      end else if (wr_grant) begin
        hold_full <= 1'b0;
      end
      if (wr_grant || !hold_full)
        starve_cnt <= '0;
      else if (rd_grant && (starve_cnt != SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// Directed bench for framebuffer_port_arbiter with a behavioural RAM and a
// read-data scoreboard fed from a shadow copy of the frame buffer.
module tb_framebuffer_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk, rst_n;
  logic          rd_valid, rd_ready, rd_data_valid;
  logic [AW-1:0] rd_addr, wr_addr, ram_addr;
  logic [DW-1:0] rd_data, wr_data, ram_din, ram_dout;
  logic          wr_valid, wr_ready, wr_pending, ram_we;

  logic [DW-1:0] mem    [2**AW];
  logic [DW-1:0] shadow [2**AW];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] saved;
  int total = 0;
  int bad   = 0;

  framebuffer_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_pending(wr_pending),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: registered address, read-first
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected data captured at read accept, compared one cycle later
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rd_data_valid) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_rd_data", rd_data, sb.pop_front());
      end
      if (rd_valid && rd_ready) sb.push_back(shadow[rd_addr]);
      if (wr_valid && wr_ready) shadow[wr_addr] = wr_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]    = DW'(i) ^ 8'hC3;
      shadow[i] = DW'(i) ^ 8'hC3;
    end
    for (int i = 0; i < 3; i++) begin
      mem[5+i]    = 8'hA5 + DW'(i);
      shadow[5+i] = 8'hA5 + DW'(i);
    end

    // Reset and enable
    rst_n = 1'b0; rd_valid = 1'b1; rd_addr = 6'h05;
    wr_valid = 1'b1; wr_addr = 6'h3F; wr_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_wr_pending", wr_pending, 0);
      chk("rst_rd_data_valid", rd_data_valid, 0);
    end
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("en0_rd_ready", rd_ready, 0);
    chk("en0_wr_ready", wr_ready, 0);
    chk("en0_ram_we", ram_we, 0);
    tick();
    @(negedge clk);
    chk("en1_rd_ready", rd_ready, 1);
    chk("en1_wr_ready", wr_ready, 1);
    chk("en1_ram_we", ram_we, 0);
    tick(); rd_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("en_drain_we", ram_we, 1);
    chk("en_drain_addr", ram_addr, 32'h3F);
    chk("en_drain_din", ram_din, 32'h77);
    chk("en_drain_pending", wr_pending, 1);
    chk("en_rd_data", rd_data, 32'hA5);
    tick();
    @(negedge clk);
    chk("idle_pending", wr_pending, 0);
    chk("idle_rdv", rd_data_valid, 0);
    tick();

    // Back-to-back reads
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1; rd_addr = 6'h05 + AW'(i);
      @(negedge clk);
      chk("b2b_rd_ready", rd_ready, 1);
      if (i > 0) begin
        chk("b2b_rdv", rd_data_valid, 1);
        chk("b2b_rd_data", rd_data, 32'hA5 + i - 1);
      end
      tick();
    end
    rd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rdv_last", rd_data_valid, 1);
    chk("b2b_rd_data_last", rd_data, 32'hA7);
    tick();

    // Write then read back
    wr_valid = 1'b1; wr_addr = 6'h10; wr_data = 8'h3C;
    @(negedge clk); chk("wr_ready", wr_ready, 1); tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 32'h10);
    chk("wr_din", ram_din, 32'h3C);
    tick();
    rd_valid = 1'b1; rd_addr = 6'h10;
    @(negedge clk); chk("rb_rd_ready", rd_ready, 1); chk("rb_we", ram_we, 0); tick();
    rd_valid = 1'b0;
    @(negedge clk); chk("rb_rdv", rd_data_valid, 1); chk("rb_data", rd_data, 32'h3C); tick();

    // Streaming writes, one per cycle
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 6'h30 + AW'(i); wr_data = 8'hD0 + DW'(i);
      @(negedge clk);
      chk("stream_wr_ready", wr_ready, 1);
      if (i > 0) begin
        chk("stream_we", ram_we, 1);
        chk("stream_addr", ram_addr, 32'h30 + i - 1);
        chk("stream_din", ram_din, 32'hD0 + i - 1);
      end
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk); chk("stream_last_addr", ram_addr, 32'h32); chk("stream_last_din", ram_din, 32'hD2); tick();
    @(negedge clk); chk("stream_empty", wr_pending, 0); tick();

    // Starvation: four read wins, then the held write is forced
    rd_valid = 1'b1; rd_addr = 6'h00; wr_valid = 1'b1; wr_addr = 6'h20; wr_data = 8'h11;
    @(negedge clk); chk("st_acc_rd", rd_ready, 1); chk("st_acc_wr", wr_ready, 1); tick();
    wr_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rd_addr = AW'(i);
      @(negedge clk);
      chk("st_rd_win", rd_ready, 1);
      chk("st_no_we", ram_we, 0);
      chk("st_pending", wr_pending, 1);
      tick();
    end
    rd_addr = 6'h05;
    @(negedge clk);
    chk("st_forced_rd_stall", rd_ready, 0);
    chk("st_forced_we", ram_we, 1);
    chk("st_forced_addr", ram_addr, 32'h20);
    chk("st_forced_din", ram_din, 32'h11);
    chk("st_cnt_sat", dut.starve_cnt, 4);
    tick();
    @(negedge clk);
    chk("st_after_rd", rd_ready, 1);
    chk("st_after_pending", wr_pending, 0);
    chk("st_cnt_clear", dut.starve_cnt, 0);
    tick();
    rd_valid = 1'b0;
    @(negedge clk); tick();

    // Read-after-write hazard on the held address
    wr_valid = 1'b1; wr_addr = 6'h08; wr_data = 8'h99;
    @(negedge clk); chk("hz_wr_ready", wr_ready, 1); tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'h08;
    @(negedge clk);
    chk("hz_rd_stall", rd_ready, 0);
    chk("hz_we", ram_we, 1);
    chk("hz_addr", ram_addr, 32'h08);
    tick();
    @(negedge clk); chk("hz_rd_ready", rd_ready, 1); chk("hz_no_we", ram_we, 0); tick();
    rd_valid = 1'b0;
    @(negedge clk); chk("hz_rdv", rd_data_valid, 1); chk("hz_data", rd_data, 32'h99); tick();

    // Reset while a write is held and reads saturate
    saved = shadow[6'h2A];
    wr_valid = 1'b1; wr_addr = 6'h2A; wr_data = 8'h5E; rd_valid = 1'b1; rd_addr = 6'h01;
    @(negedge clk); chk("mr_acc_rd", rd_ready, 1); chk("mr_acc_wr", wr_ready, 1); tick();
    wr_valid = 1'b0; rd_addr = 6'h02;
    @(negedge clk); chk("mr_pending", wr_pending, 1); chk("mr_rd_win", rd_ready, 1); tick();
    chk("mr_rdv_before", rd_data_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_pending_drop", wr_pending, 0);
    chk("mr_rdv_drop", rd_data_valid, 0);
    chk("mr_rd_ready", rd_ready, 0);
    chk("mr_we", ram_we, 0);
    shadow[6'h2A] = saved;
    rd_valid = 1'b0;
    @(negedge clk); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_post_we", ram_we, 0);
      chk("mr_post_pending", wr_pending, 0);
      tick();
    end
    rd_valid = 1'b1; rd_addr = 6'h2A;
    @(negedge clk); chk("mr_rb_ready", rd_ready, 1); tick();
    rd_valid = 1'b0;
    @(negedge clk); chk("mr_rb_rdv", rd_data_valid, 1); chk("mr_rb_data", rd_data, saved); tick();

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
